// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit accumulator CPU.
// Holds the opcode encoding, the fetch FSM state type, the instruction
// field positions and the default reset PC.
package cpu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    HALT  = 4'b0001,
    LOAD  = 4'b0010,
    STORE = 4'b0011,
    CLEAR = 4'b0100,
    SKIP  = 4'b0101,
    JUMP  = 4'b0110,
    SUB   = 4'b0111,
    AND   = 4'b1000,
    OR    = 4'b1001
  } opcode_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } fetch_state_t;

  localparam int MODE_BIT = 31;
  localparam int OPC_MSB  = 30;
  localparam int OPC_LSB  = 27;
  localparam int OPND_MSB = 26;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h100;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: RAM port, execute handshake with decoded fields,
// and the redirect/skip/halt controls from execute.
//   master : the fetch unit side
//   slave  : the RAM/execute side (testbench or surrounding core)
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32
);
  logic                  bus_grant;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cs;
  logic                  mem_oe;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           ir;
  logic                  imm_mode;
  logic [3:0]            opcode;
  logic [26:0]           operand;
  logic [31:0]           instr_pc;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  skip_valid;
  logic                  halted;

  modport master (
    input  bus_grant, mem_rdata, instr_ready, redirect_valid, redirect_pc, skip_valid,
    output mem_addr, mem_cs, mem_oe, mem_we, instr_valid, ir, imm_mode, opcode,
           operand, instr_pc, halted
  );

  modport slave (
    output bus_grant, mem_rdata, instr_ready, redirect_valid, redirect_pc, skip_valid,
    input  mem_addr, mem_cs, mem_oe, mem_we, instr_valid, ir, imm_mode, opcode,
           operand, instr_pc, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the instruction word at PC from a registered-read RAM,
// latches it into IR, advances PC and presents the decoded instruction to
// execute over valid/ready. Execute can redirect (jump) or skip the next
// instruction; retiring HALT parks the unit until reset.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.master (RAM port, execute handshake,
//              redirect/skip inputs, halted status)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 28,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          PC_STEP    = 2,
  parameter int          RD_LATENCY = 1
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_t          state, state_n;
  logic [31:0]           pc, pc_n;
  logic [31:0]           ir_q, ir_n;
  logic [31:0]           ipc_q, ipc_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  cs_q, cs_n;
  logic [7:0]            cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  is_halt;

  assign rdata   = bus.mem_rdata;
  assign is_halt = !ir_q[MODE_BIT] && (ir_q[OPC_MSB:OPC_LSB] == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      ir_q   <= '0;
      ipc_q  <= '0;
      addr_q <= '0;
      cs_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      ir_q   <= ir_n;
      ipc_q  <= ipc_n;
      addr_q <= addr_n;
      cs_q   <= cs_n;
      cnt_q  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir_q;
    ipc_n   = ipc_q;
    addr_n  = addr_q;
    cs_n    = cs_q;
    cnt_n   = cnt_q;
    // Redirect overrides everything below it; the in-flight or presented
    // instruction is simply abandoned.
    if (state != S_HALT && bus.redirect_valid) begin
      pc_n    = bus.redirect_pc;
      cs_n    = 1'b0;
      state_n = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          // A skip arriving here just moves PC; the request waits a cycle
          // so the RAM is always addressed with the final PC.
          if (bus.skip_valid) begin
            pc_n = pc + STEP;
          end else if (bus.bus_grant) begin
            addr_n  = pc[ADDR_WIDTH-1:0];
            cs_n    = 1'b1;
            cnt_n   = 8'(RD_LATENCY);
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.skip_valid) begin
            pc_n    = pc + STEP;
            cs_n    = 1'b0;
            state_n = S_REQ;
          end else if (cnt_q == '0) begin
            ir_n    = rdata[31:0];
            ipc_n   = pc;
            pc_n    = pc + STEP;
            cs_n    = 1'b0;
            state_n = S_VALID;
          end else begin
            cnt_n = cnt_q - 8'd1;
          end
        end
        S_VALID: begin
          // Skip moves the next fetch PC but leaves the presented
          // instruction in place until execute accepts it.
          if (bus.skip_valid) pc_n = pc + STEP;
          if (bus.instr_ready) state_n = is_halt ? S_HALT : S_REQ;
        end
        S_HALT:  cs_n = 1'b0;
        default: state_n = S_REQ;
      endcase
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_cs      = cs_q;
  assign bus.mem_oe      = cs_q;
  assign bus.mem_we      = 1'b0;
  assign bus.instr_valid = (state == S_VALID);
  assign bus.halted      = (state == S_HALT);
  assign bus.ir          = ir_q;
  assign bus.imm_mode    = ir_q[MODE_BIT];
  assign bus.opcode      = ir_q[OPC_MSB:OPC_LSB];
  assign bus.operand     = ir_q[OPND_MSB:0];
  assign bus.instr_pc    = ipc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// randomized run, all checked against an architectural next-fetch-PC model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc ();
  instr_fetch_unit dut (.clk(clk), .rst(rst), .bus(ifc));

  // Registered-read RAM, one cycle latency, 1K-word window.
  logic [31:0] mem [0:1023];
  always @(posedge clk)
    if (ifc.mem_cs && ifc.mem_oe) ifc.mem_rdata <= mem[ifc.mem_addr[9:0]];

  int checks = 0;
  int errors = 0;

  // Reference model state: the PC the fetch unit should fetch next.
  logic [31:0] nf;
  logic [31:0] issue_pc, last_issue, held_ir;
  bit          m_halted, p_cs, p_valid, got_new;
  int          cyc, issue_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_halt_word(input logic [31:0] w);
    return w[31:27] == 5'b00001;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (is_halt_word(w)) w[31] = 1'b1;
    return w;
  endfunction

  task automatic model_reset();
    nf = 32'h100; m_halted = 0; p_cs = 0; p_valid = 0; got_new = 0;
  endtask

  task automatic observe();
    cyc++;
    chk("we", 32'(ifc.mem_we), 0);
    if (m_halted) begin
      chk("halted", 32'(ifc.halted), 1);
      chk("halt_cs", 32'(ifc.mem_cs), 0);
      chk("halt_valid", 32'(ifc.instr_valid), 0);
    end else begin
      chk("not_halted", 32'(ifc.halted), 0);
      if (ifc.mem_cs && !p_cs) begin
        chk("issue_addr", 32'(ifc.mem_addr), {4'h0, nf[27:0]});
        chk("issue_oe", 32'(ifc.mem_oe), 1);
        issue_pc = nf; last_issue = nf; issue_cyc = cyc;
      end
      if (ifc.instr_valid && !p_valid) begin
        got_new = 1;
        chk("instr_pc", ifc.instr_pc, issue_pc);
        chk("ir", ifc.ir, mem[issue_pc[9:0]]);
        chk("latency", 32'(cyc - issue_cyc), 2);
        chk("fields", {ifc.imm_mode, ifc.opcode, ifc.operand}, mem[issue_pc[9:0]]);
        held_ir = mem[issue_pc[9:0]];
        nf = issue_pc + 32'd2;
      end else if (ifc.instr_valid) begin
        chk("ir_stable", ifc.ir, held_ir);
        chk("valid_cs", 32'(ifc.mem_cs), 0);
      end
    end
    p_cs = ifc.mem_cs; p_valid = ifc.instr_valid;
  endtask

  // One cycle: check outputs, drive inputs for the next edge, predict.
  task automatic step(input bit g, input bit r, input bit s, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    observe();
    ifc.bus_grant = g; ifc.instr_ready = r; ifc.skip_valid = s;
    ifc.redirect_valid = rd; ifc.redirect_pc = rpc;
    if (!m_halted) begin
      if (rd) nf = rpc;
      else begin
        if (s) nf = nf + 32'd2;
        if (ifc.instr_valid && r && is_halt_word(ifc.ir)) m_halted = 1;
      end
    end
  endtask

  task automatic wait_valid();
    got_new = 0;
    for (int i = 0; i < 60 && !got_new; i++) step(1, 0, 0, 0, 0);
    chk("got_valid", 32'(got_new), 1);
  endtask

  task automatic accept();
    step(1, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    ifc.bus_grant = 0; ifc.instr_ready = 0; ifc.skip_valid = 0;
    ifc.redirect_valid = 0; ifc.redirect_pc = 0;
    @(negedge clk);
    chk("rst_cs_next", 32'(ifc.mem_cs), 0);
    @(negedge clk);
    chk("rst_valid", 32'(ifc.instr_valid), 0);
    chk("rst_oe", 32'(ifc.mem_oe), 0);
    chk("rst_we", 32'(ifc.mem_we), 0);
    chk("rst_addr", 32'(ifc.mem_addr), 0);
    chk("rst_halted", 32'(ifc.halted), 0);
    chk("rst_ir", ifc.ir, 0);
    chk("rst_ipc", ifc.instr_pc, 0);
    rst = 0;
    model_reset();
  endtask

  initial begin
    cyc = 0; issue_cyc = 0; issue_pc = 0; last_issue = 0; held_ir = 0;
    model_reset();
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    mem[10'h100] = 32'h1000011E;
    mem[10'h104] = 32'h1800011C;
    mem[10'h112] = 32'hB8000001;
    mem[10'h118] = 32'h08000000;
    do_reset();

    // Reset fetch
    wait_valid();
    chk("first_issue", last_issue, 32'h100);
    chk("first_opc", 32'(ifc.opcode), 32'h2);
    chk("first_opnd", 32'(ifc.operand), 32'h11E);
    chk("first_ipc", ifc.instr_pc, 32'h100);
    accept();
    wait_valid();
    chk("second_issue", last_issue, 32'h102);
    accept();

    // Backpressure at 0x104: five cycles not ready, accepted on the sixth
    wait_valid();
    repeat (4) step(1, 0, 0, 0, 0);
    accept();
    wait_valid();
    chk("after_bp_issue", last_issue, 32'h106);
    accept();
    repeat (5) begin wait_valid(); accept(); end

    // Immediate SUB at 0x112, then skip while pc=0x114
    wait_valid();
    chk("imm_mode", 32'(ifc.imm_mode), 1);
    chk("imm_opc", 32'(ifc.opcode), 32'h7);
    chk("imm_opnd", 32'(ifc.operand), 1);
    step(1, 0, 1, 0, 0);
    accept();
    wait_valid();
    chk("skip_issue", last_issue, 32'h116);

    // Redirect beats ready: instruction dropped, refetch 0x116
    step(1, 1, 0, 1, 32'h116);
    wait_valid();
    chk("redir_issue", last_issue, 32'h116);
    accept();

    // HALT at 0x118
    wait_valid();
    chk("halt_opc", 32'(ifc.opcode), 32'h1);
    accept();
    step(1, 1, 0, 0, 0);
    chk("halted_set", 32'(ifc.halted), 1);
    for (int i = 0; i < 20; i++) step(1, 1, (i == 9), (i == 5), 32'h100);
    do_reset();
    wait_valid();
    chk("post_halt_issue", last_issue, 32'h100);
    accept();

    // Bus stall then reset mid-WAIT
    repeat (3) begin
      step(0, 1, 0, 0, 0);
      chk("stall_cs", 32'(ifc.mem_cs), 0);
    end
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("wait_cs", 32'(ifc.mem_cs), 1);
    do_reset();
    wait_valid();
    chk("rst_wait_issue", last_issue, 32'h100);
    accept();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rd = ($urandom_range(0, 99) < 5);
      step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 5), rd, 32'h100 + 32'(2 * $urandom_range(0, 255)));
    end
    step(1, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Synthesizable fetch stage for the 32-bit accumulator CPU; sits directly upstream of the execute stage.
- Reads instruction words from single_port_sync_ram_large at PC, latches IR, and advances PC by 2.
- Splits IR into mode/opcode/operand and hands the instruction to execute over a valid/ready handshake.
- Accepts jump redirects and skip requests from execute; stops fetching permanently on HALT.

Parameters:
- ADDR_WIDTH, 28, RAM address width; mem_addr = pc[ADDR_WIDTH-1:0].
- DATA_WIDTH, 32, instruction/RAM word width.
- RESET_PC, 32'h100, PC value after reset.
- PC_STEP, 2, PC increment per instruction and per skip.
- RD_LATENCY, 1, RAM registered-read delay in cycles (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_grant  in  1  fetch may start a RAM access this cycle (execute not using RAM).
- mem_addr  out  ADDR_WIDTH  RAM address (registered).
- mem_cs  out  1  RAM chip select (registered).
- mem_oe  out  1  RAM output enable (registered).
- mem_we  out  1  RAM write enable; constant 0.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- instr_valid  out  1  instruction presented to execute.
- instr_ready  in  1  execute accepts the instruction.
- ir  out  32  full instruction word.
- imm_mode  out  1  ir[31].
- opcode  out  4  ir[30:27].
- operand  out  27  ir[26:0].
- instr_pc  out  32  address the instruction was fetched from.
- redirect_valid  in  1  jump request.
- redirect_pc  in  32  jump target (zero-extended by execute).
- skip_valid  in  1  skip the next instruction.
- halted  out  1  HALT retired; fetching stopped.

Behaviour:
- Reset values (sampled rst=1):
  - state=S_REQ, pc=RESET_PC.
  - ir=0, instr_pc=0, instr_valid=0.
  - mem_cs=0, mem_oe=0, mem_we=0, mem_addr=0, halted=0.
- S_REQ:
  - If bus_grant=1: register mem_addr<=pc, mem_cs<=1, mem_oe<=1, load counter with RD_LATENCY, go to S_WAIT.
  - Otherwise hold, with cs=0.
- S_WAIT:
  - Hold addr/cs/oe; decrement the counter each edge.
  - On the edge where the counter is 0: ir<=mem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, cs<=0, oe<=0, go to S_VALID.
  - Capture edge is RD_LATENCY+1 edges after the address edge.
- S_VALID:
  - instr_valid=1; ir and the decoded fields stay stable while instr_ready=0; no RAM access.
  - On instr_ready=1 with imm_mode=0 and opcode=4'b0001: go to S_HALT.
  - On instr_ready=1 otherwise: go to S_REQ.
- S_HALT:
  - halted=1, instr_valid=0, cs=0.
  - redirect_valid and skip_valid are ignored; only rst exits.
- Redirect (any state except S_HALT):
  - pc<=redirect_pc; any pending or in-flight instruction is discarded (instr_valid<=0, cs/oe<=0); next state S_REQ.
  - Execute asserts redirect only after it has consumed the jump.
- Skip (any state except S_HALT):
  - pc<=pc+PC_STEP; if in S_WAIT, the fetch is aborted and state goes to S_REQ.
  - In S_VALID, the skip does not consume the presented instruction.
- Simultaneous events:
  - redirect_valid beats skip_valid.
  - redirect_valid beats instr_ready (the instruction is dropped).
  - rst beats everything; rst mid-S_WAIT drops cs on the next edge.
- Arithmetic: pc is 32 bits and wraps modulo 2^32; no alignment check.
- Throughput: with RD_LATENCY=1 and instr_ready tied high, one instruction every 4 cycles (REQ, WAIT, WAIT/capture, VALID).

Decomposition:
- Shared package cpu_pkg:
  - opcode_t enum: ADD=0000, HALT=0001, LOAD=0010, STORE=0011, CLEAR=0100, SKIP=0101, JUMP=0110, SUB=0111, AND=1000, OR=1001.
  - fetch_state_t: S_REQ, S_WAIT, S_VALID, S_HALT.
  - Field position constants: MODE_BIT=31, OPC_MSB/LSB=30/27, OPND_MSB=26.
  - Default RESET_PC.
- No sub-module; field decode is inline wiring.

Test Plan:
- Reset fetch: mem[0x100]=0x1000011E, bus_grant=1, instr_ready=1 -> mem_addr=0x100, cs=oe=1; instr_valid high in cycle 3 after reset release; opcode=0010, operand=0x11E, instr_pc=0x100; next mem_addr=0x102.
- Backpressure: instr_ready=0 for 5 cycles at instr 0x1800011C -> ir stable, cs=0 throughout; accepted on the 6th cycle; next fetch at 0x106.
- Immediate and skip: fetch 0xB8000001 -> imm_mode=1, opcode=0111, operand=1. Then skip_valid while pc=0x114 -> next mem_addr=0x116, not 0x114.
- Redirect: redirect_valid with redirect_pc=0x116 and instr_ready=1 in the same S_VALID cycle -> instruction dropped; next mem_addr=0x116.
- Halt: mem[0x118]=0x08000000 -> delivered with opcode=0001; halted=1 after accept; cs=0 for 20 cycles despite a redirect to 0x100; rst -> halted=0, fetch resumes at 0x100.
- Stall and reset: bus_grant=0 for 3 cycles -> cs stays 0. Then rst in S_WAIT -> cs=0 the next cycle, pc=0x100.
